// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates three requesters (video fetch, CPU, disk DMA) onto one
// asynchronous 32-bit SRAM made from two 16-bit chips, and sequences the
// chip strobes for each read or write.
//
// Ports:
//   clk, reset_n             system clock, asynchronous active-low reset
//   vga_req/vga_addr/vga_ack video read requester (read-only)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_ack   CPU requester
//   dsk_req/dsk_we/dsk_addr/dsk_wdata/dsk_ack   disk DMA requester
//   rd_data                  shared read data, valid in the ack cycle
//   sram_a, sram_oe_n, sram_we_n               shared SRAM address/strobes
//   sram1_io, sram2_io       data bus, low and high 16-bit halves
//   sram1/2_ce_n, sram1/2_ub_n, sram1/2_lb_n   chip and byte enables
//
// Parameters:
//   RD_WAIT  extra read-strobe cycles before data is sampled (0..7)
//   WR_WAIT  extra we_n-low cycles per write (0..7)

module ram_arbiter #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        vga_req,
  input  logic [17:0] vga_addr,
  output logic        vga_ack,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,

  input  logic        dsk_req,
  input  logic        dsk_we,
  input  logic [17:0] dsk_addr,
  input  logic [31:0] dsk_wdata,
  output logic        dsk_ack,

  output logic [31:0] rd_data,

  output logic [17:0] sram_a,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  inout  wire  [15:0] sram1_io,
  inout  wire  [15:0] sram2_io,
  output logic        sram1_ce_n,
  output logic        sram2_ce_n,
  output logic        sram1_ub_n,
  output logic        sram1_lb_n,
  output logic        sram2_ub_n,
  output logic        sram2_lb_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OWN_VGA,
    OWN_CPU,
    OWN_DSK
  } owner_t;

  localparam logic [2:0] RD_LOAD = 3'(RD_WAIT);
  localparam logic [2:0] WR_LOAD = 3'(WR_WAIT);

  state_t      state;
  state_t      state_next;
  logic [2:0]  wait_cnt;
  logic [2:0]  wait_cnt_next;

  owner_t      owner;
  owner_t      grant_owner;
  logic        grant;
  logic        grant_we;
  logic [17:0] grant_addr;
  logic [31:0] grant_wdata;

  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  // Round-robin pointer between cpu and dsk: 0 favours cpu, 1 favours dsk.
  logic        ptr_dsk;

  logic        done;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        drive_io;
  logic        any_ack;

  assign any_ack = vga_ack | cpu_ack | dsk_ack;

  // Grant selection. No grant is made while an ack is still visible, which
  // gives the requester one cycle to drop its request before we could
  // re-grant it. Video always wins; cpu/dsk ties go to the pointer's choice.
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_VGA;
    grant_we    = 1'b0;
    grant_addr  = vga_addr;
    grant_wdata = '0;
    if (state == IDLE && !any_ack) begin
      if (vga_req) begin
        grant = 1'b1;
      end else if (cpu_req && (!ptr_dsk || !dsk_req)) begin
        grant       = 1'b1;
        grant_owner = OWN_CPU;
        grant_we    = cpu_we;
        grant_addr  = cpu_addr;
        grant_wdata = cpu_wdata;
      end else if (dsk_req) begin
        grant       = 1'b1;
        grant_owner = OWN_DSK;
        grant_we    = dsk_we;
        grant_addr  = dsk_addr;
        grant_wdata = dsk_wdata;
      end
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and strobe decode. Strobes are decoded straight from the
  // state register so that an asynchronous reset releases them at once.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    done          = 1'b0;
    ce_n          = 1'b1;
    oe_n          = 1'b1;
    we_n          = 1'b1;
    drive_io      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_next    = grant_we ? WR_SETUP : RD;
          wait_cnt_next = grant_we ? 3'd0 : RD_LOAD;
        end
      end
      RD: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        if (wait_cnt == 3'd0) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      WR_SETUP: begin
        ce_n          = 1'b0;
        drive_io      = 1'b1;
        state_next    = WR_PULSE;
        wait_cnt_next = WR_LOAD;
      end
      WR_PULSE: begin
        ce_n     = 1'b0;
        we_n     = 1'b0;
        drive_io = 1'b1;
        if (wait_cnt == 3'd0) begin
          state_next = WR_HOLD;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      WR_HOLD: begin
        ce_n       = 1'b0;
        drive_io   = 1'b1;
        state_next = IDLE;
        done       = 1'b1;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Access registers: request fields are captured only at grant, so the
  // requester may change or drop its inputs without disturbing the access.
  // Acks are registered so each lasts exactly one cycle after completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      owner   <= OWN_VGA;
      ptr_dsk <= 1'b0;
      rd_data <= '0;
      vga_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dsk_ack <= 1'b0;
    end else begin
      vga_ack <= done && (owner == OWN_VGA);
      cpu_ack <= done && (owner == OWN_CPU);
      dsk_ack <= done && (owner == OWN_DSK);
      if (grant) begin
        addr_q  <= grant_addr;
        wdata_q <= grant_wdata;
        owner   <= grant_owner;
        // Point away from whichever of cpu/dsk was just served.
        if (grant_owner != OWN_VGA) begin
          ptr_dsk <= (grant_owner == OWN_CPU);
        end
      end
      if (state == RD && done) begin
        rd_data <= {sram2_io, sram1_io};
      end
    end
  end

  assign sram_a     = addr_q;
  assign sram_oe_n  = oe_n;
  assign sram_we_n  = we_n;
  assign sram1_ce_n = ce_n;
  assign sram2_ce_n = ce_n;
  assign sram1_ub_n = ce_n;
  assign sram1_lb_n = ce_n;
  assign sram2_ub_n = ce_n;
  assign sram2_lb_n = ce_n;

  // Write data is on the bus for setup, pulse and hold; released otherwise.
  assign sram1_io = drive_io ? wdata_q[15:0]  : 16'bz;
  assign sram2_io = drive_io ? wdata_q[31:16] : 16'bz;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with a behavioural asynchronous SRAM
// on the data bus. Pull-ups on the bus make a released bus read as all ones.
// Expected acks (owner and read data) are queued when requests are driven
// and popped as acks appear.

`timescale 1ns/1ps

module tb_ram_arbiter;

  localparam logic [1:0] ID_VGA = 2'd0;
  localparam logic [1:0] ID_CPU = 2'd1;
  localparam logic [1:0] ID_DSK = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        vga_req = 1'b0;
  logic [17:0] vga_addr = '0;
  logic        vga_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic        dsk_req = 1'b0;
  logic        dsk_we = 1'b0;
  logic [17:0] dsk_addr = '0;
  logic [31:0] dsk_wdata = '0;
  logic        dsk_ack;
  logic [31:0] rd_data;
  logic [17:0] sram_a;
  logic        sram_oe_n, sram_we_n;
  wire  [15:0] sram1_io, sram2_io;
  logic        sram1_ce_n, sram2_ce_n, sram1_ub_n, sram1_lb_n, sram2_ub_n, sram2_lb_n;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  id;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];

  ram_arbiter #(.RD_WAIT(1), .WR_WAIT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dsk_req(dsk_req), .dsk_we(dsk_we), .dsk_addr(dsk_addr), .dsk_wdata(dsk_wdata), .dsk_ack(dsk_ack),
    .rd_data(rd_data), .sram_a(sram_a), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram1_io(sram1_io), .sram2_io(sram2_io),
    .sram1_ce_n(sram1_ce_n), .sram2_ce_n(sram2_ce_n),
    .sram1_ub_n(sram1_ub_n), .sram1_lb_n(sram1_lb_n),
    .sram2_ub_n(sram2_ub_n), .sram2_lb_n(sram2_lb_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar b = 0; b < 16; b++) begin : g_pull
    pullup (sram1_io[b]);
    pullup (sram2_io[b]);
  end

  // Behavioural SRAM: drives the bus while selected for read, stores the
  // bus value on the rising edge of we_n (unless reset aborted the write).
  wire sram_rd = !sram1_ce_n && !sram_oe_n && sram_we_n;
  assign sram1_io = sram_rd ? mem[sram_a[7:0]][15:0]  : 16'bz;
  assign sram2_io = sram_rd ? mem[sram_a[7:0]][31:16] : 16'bz;

  always @(posedge sram_we_n) begin
    if (reset_n && !sram1_ce_n) mem[sram_a[7:0]] <= {sram2_io, sram1_io};
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_word(i);
      exp_mem[i] = init_word(i);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic rd, input logic [17:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.id = id;
    e.rd = rd;
    if (rd) begin
      e.data = exp_mem[addr[7:0]];
    end else begin
      e.data = wdata;
      exp_mem[addr[7:0]] = wdata;
    end
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next ack, sampling on falling edges, and
  // reports what was seen along the way.
  task automatic wait_ack(input int budget, output bit seen, output logic [1:0] id,
                          output logic [31:0] data, output int at_cyc, output bit multi,
                          output int we_low, output logic [31:0] wr_bus, output logic [17:0] wr_addr);
    seen = 1'b0; id = '0; data = '0; at_cyc = 0; multi = 1'b0;
    we_low = 0; wr_bus = '0; wr_addr = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        we_low++;
        wr_bus  = {sram2_io, sram1_io};
        wr_addr = sram_a;
      end
      if (vga_ack || cpu_ack || dsk_ack) begin
        seen   = 1'b1;
        at_cyc = cyc;
        data   = rd_data;
        multi  = (int'(vga_ack) + int'(cpu_ack) + int'(dsk_ack)) > 1;
        id     = vga_ack ? ID_VGA : (cpu_ack ? ID_CPU : ID_DSK);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({vga_ack, cpu_ack, dsk_ack} !== 3'b000) begin errors++; $display("[TB] FAIL rst_acks: got %b required 000", {vga_ack, cpu_ack, dsk_ack}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_data: got %h required 0", rd_data); end
    checks++; if (sram_a !== 18'h0) begin errors++; $display("[TB] FAIL rst_sram_a: got %h required 0", sram_a); end
    checks++; if ({sram_oe_n, sram_we_n, sram1_ce_n, sram2_ce_n, sram1_ub_n, sram1_lb_n, sram2_ub_n, sram2_lb_n} !== 8'hFF) begin errors++; $display("[TB] FAIL rst_strobes: got %b required all ones", {sram_oe_n, sram_we_n, sram1_ce_n, sram2_ce_n, sram1_ub_n, sram1_lb_n, sram2_ub_n, sram2_lb_n}); end
    checks++; if ({sram2_io, sram1_io} !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rst_io_hiz: got %h required released bus", {sram2_io, sram1_io}); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);
    checks++; if ({sram_oe_n, sram_we_n, sram1_ce_n} !== 3'b111) begin errors++; $display("[TB] FAIL idle_strobes: got %b required 111", {sram_oe_n, sram_we_n, sram1_ce_n}); end
  endtask

  task automatic test_cpu_write();
    bit seen, multi; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low, k; exp_t e;
    idle_cycles(2);
    checks++; if ({sram2_io, sram1_io} !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wr_io_before: got %h required released bus", {sram2_io, sram1_io}); end
    push_exp(ID_CPU, 1'b0, 18'h00010, 32'h1234_5678);
    cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    k = cyc;
    wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    cpu_req = 1'b0;
    if (!seen) begin
      checks++; errors++; $display("[TB] FAIL wr_ack: no ack within 20 cycles, required cpu ack");
      if (sb.size() != 0) e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL wr_owner: got %0d required %0d", id, e.id); end
      checks++; if (at_cyc != k + 5) begin errors++; $display("[TB] FAIL wr_latency: ack at cycle %0d required %0d", at_cyc, k + 5); end
      checks++; if (we_low != 2) begin errors++; $display("[TB] FAIL wr_pulse_len: we_n low %0d cycles required 2", we_low); end
      checks++; if (wr_bus !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wr_bus_data: got %h required 12345678", wr_bus); end
      checks++; if (wr_addr !== 18'h00010) begin errors++; $display("[TB] FAIL wr_addr: got %h required 00010", wr_addr); end
      checks++; if (multi) begin errors++; $display("[TB] FAIL wr_one_ack: got several acks required one"); end
    end
    checks++; if ({sram2_io, sram1_io} !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wr_io_after: got %h required released bus", {sram2_io, sram1_io}); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL wr_we_after: got %b required 1", sram_we_n); end
  endtask

  task automatic test_cpu_read();
    bit seen, multi; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low, k; exp_t e;
    idle_cycles(2);
    push_exp(ID_CPU, 1'b1, 18'h00010, '0);
    cpu_we = 1'b0; cpu_addr = 18'h00010; cpu_req = 1'b1;
    k = cyc;
    wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    cpu_req = 1'b0;
    if (!seen) begin
      checks++; errors++; $display("[TB] FAIL rd_ack: no ack within 20 cycles, required cpu ack");
      if (sb.size() != 0) e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL rd_owner: got %0d required %0d", id, e.id); end
      checks++; if (at_cyc != k + 3) begin errors++; $display("[TB] FAIL rd_latency: ack at cycle %0d required %0d", at_cyc, k + 3); end
      checks++; if (data !== e.data) begin errors++; $display("[TB] FAIL rd_data: got %h required %h", data, e.data); end
      checks++; if (we_low != 0) begin errors++; $display("[TB] FAIL rd_no_we: we_n low %0d cycles required 0", we_low); end
    end
  endtask

  task automatic test_latch_and_drop();
    bit seen, multi; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low, k; exp_t e;
    idle_cycles(2);
    push_exp(ID_CPU, 1'b0, 18'h00060, 32'hA5A5_5A5A);
    cpu_we = 1'b1; cpu_addr = 18'h00060; cpu_wdata = 32'hA5A5_5A5A; cpu_req = 1'b1;
    k = cyc;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 18'h00061; cpu_wdata = 32'hFFFF_0000; cpu_req = 1'b0;
    wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    if (!seen) begin
      checks++; errors++; $display("[TB] FAIL drop_ack: no ack within 20 cycles, required cpu ack");
      if (sb.size() != 0) e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL drop_owner: got %0d required %0d", id, e.id); end
      checks++; if (at_cyc != k + 5) begin errors++; $display("[TB] FAIL drop_latency: ack at cycle %0d required %0d", at_cyc, k + 5); end
      checks++; if (we_low != 2) begin errors++; $display("[TB] FAIL latch_we: we_n low %0d cycles required 2", we_low); end
      checks++; if (wr_bus !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL latch_wdata: got %h required a5a55a5a", wr_bus); end
      checks++; if (wr_addr !== 18'h00060) begin errors++; $display("[TB] FAIL latch_addr: got %h required 00060", wr_addr); end
    end
    idle_cycles(2);
    push_exp(ID_VGA, 1'b1, 18'h00060, '0);
    vga_addr = 18'h00060; vga_req = 1'b1;
    k = cyc;
    wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    vga_req = 1'b0;
    if (!seen) begin
      checks++; errors++; $display("[TB] FAIL vga_rd_ack: no ack within 20 cycles, required vga ack");
      if (sb.size() != 0) e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL vga_rd_owner: got %0d required %0d", id, e.id); end
      checks++; if (at_cyc != k + 3) begin errors++; $display("[TB] FAIL vga_rd_latency: ack at cycle %0d required %0d", at_cyc, k + 3); end
      checks++; if (data !== e.data) begin errors++; $display("[TB] FAIL vga_rd_data: got %h required %h", data, e.data); end
    end
  endtask

  task automatic test_priority();
    bit seen, multi; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low, k; exp_t e; int ack_at [3];
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);
    push_exp(ID_VGA, 1'b1, 18'h00020, '0);
    push_exp(ID_CPU, 1'b0, 18'h00030, 32'hCAFE_F00D);
    push_exp(ID_DSK, 1'b1, 18'h00040, '0);
    vga_addr = 18'h00020;
    cpu_we = 1'b1; cpu_addr = 18'h00030; cpu_wdata = 32'hCAFE_F00D;
    dsk_we = 1'b0; dsk_addr = 18'h00040;
    vga_req = 1'b1; cpu_req = 1'b1; dsk_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      ack_at[i] = 0;
      wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
      if (!seen) begin
        checks++; errors++; $display("[TB] FAIL prio_ack%0d: no ack within 20 cycles", i);
        if (sb.size() != 0) e = sb.pop_front();
      end else begin
        ack_at[i] = at_cyc;
        e = sb.pop_front();
        checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL prio_order%0d: got owner %0d required %0d", i, id, e.id); end
        if (e.rd) begin
          checks++; if (data !== e.data) begin errors++; $display("[TB] FAIL prio_data%0d: got %h required %h", i, data, e.data); end
        end
        checks++; if (multi) begin errors++; $display("[TB] FAIL prio_one_ack%0d: got several acks required one", i); end
        if (id == ID_VGA) vga_req = 1'b0;
        else if (id == ID_CPU) cpu_req = 1'b0;
        else dsk_req = 1'b0;
      end
    end
    vga_req = 1'b0; cpu_req = 1'b0; dsk_req = 1'b0;
    checks++; if (ack_at[0] != k + 3) begin errors++; $display("[TB] FAIL prio_first_latency: ack at %0d required %0d", ack_at[0], k + 3); end
    checks++; if (ack_at[1] - ack_at[0] != 6) begin errors++; $display("[TB] FAIL prio_gap1: %0d cycles required 6", ack_at[1] - ack_at[0]); end
    checks++; if (ack_at[2] - ack_at[1] != 4) begin errors++; $display("[TB] FAIL prio_gap2: %0d cycles required 4", ack_at[2] - ack_at[1]); end
  endtask

  task automatic test_round_robin();
    bit seen, multi; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low; exp_t e;
    idle_cycles(2);
    push_exp(ID_CPU, 1'b1, 18'h00010, '0);
    push_exp(ID_DSK, 1'b0, 18'h00050, 32'hD0D0_0050);
    push_exp(ID_CPU, 1'b1, 18'h00030, '0);
    push_exp(ID_DSK, 1'b0, 18'h00051, 32'hD1D1_0051);
    push_exp(ID_VGA, 1'b1, 18'h00050, '0);
    push_exp(ID_CPU, 1'b1, 18'h00040, '0);
    push_exp(ID_DSK, 1'b0, 18'h00052, 32'hD2D2_0052);
    cpu_we = 1'b0; cpu_addr = 18'h00010;
    dsk_we = 1'b1; dsk_addr = 18'h00050; dsk_wdata = 32'hD0D0_0050;
    cpu_req = 1'b1; dsk_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        repeat (2) @(negedge clk);
        vga_addr = 18'h00050; vga_req = 1'b1;
      end
      wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
      if (!seen) begin
        checks++; errors++; $display("[TB] FAIL rr_ack%0d: no ack within 20 cycles", i);
        if (sb.size() != 0) e = sb.pop_front();
      end else begin
        e = sb.pop_front();
        checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL rr_order%0d: got owner %0d required %0d", i, id, e.id); end
        if (e.rd) begin
          checks++; if (data !== e.data) begin errors++; $display("[TB] FAIL rr_data%0d: got %h required %h", i, data, e.data); end
        end
        checks++; if (multi) begin errors++; $display("[TB] FAIL rr_one_ack%0d: got several acks required one", i); end
      end
      case (i)
        0: cpu_addr = 18'h00030;
        1: begin dsk_addr = 18'h00051; dsk_wdata = 32'hD1D1_0051; end
        2: cpu_addr = 18'h00040;
        3: begin dsk_addr = 18'h00052; dsk_wdata = 32'hD2D2_0052; end
        4: vga_req = 1'b0;
        5: cpu_req = 1'b0;
        default: dsk_req = 1'b0;
      endcase
    end
    vga_req = 1'b0; cpu_req = 1'b0; dsk_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen, multi, found; logic [1:0] id; logic [31:0] data, wr_bus; logic [17:0] wr_addr;
    int at_cyc, we_low, k; exp_t e;
    idle_cycles(2);
    dsk_we = 1'b1; dsk_addr = 18'h00070; dsk_wdata = 32'h0BAD_F00D; dsk_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!sram_we_n) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL abort_pulse: we_n never went low, required a write pulse"); end
    #1 reset_n = 1'b0; dsk_req = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_we: got %b required 1", sram_we_n); end
    checks++; if (sram1_ce_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_ce: got %b required 1", sram1_ce_n); end
    checks++; if ({sram2_io, sram1_io} !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL abort_io_hiz: got %h required released bus", {sram2_io, sram1_io}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL abort_rd_data: got %h required 0", rd_data); end
    checks++; if (sram_a !== 18'h0) begin errors++; $display("[TB] FAIL abort_sram_a: got %h required 0", sram_a); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(6, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    checks++; if (seen) begin errors++; $display("[TB] FAIL abort_no_ack: got ack from owner %0d required none", id); end
    push_exp(ID_CPU, 1'b1, 18'h00010, '0);
    cpu_we = 1'b0; cpu_addr = 18'h00010; cpu_req = 1'b1;
    k = cyc;
    wait_ack(20, seen, id, data, at_cyc, multi, we_low, wr_bus, wr_addr);
    cpu_req = 1'b0;
    if (!seen) begin
      checks++; errors++; $display("[TB] FAIL post_abort_ack: no ack within 20 cycles, required cpu ack");
      if (sb.size() != 0) e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++; if (id !== e.id) begin errors++; $display("[TB] FAIL post_abort_owner: got %0d required %0d", id, e.id); end
      checks++; if (at_cyc != k + 3) begin errors++; $display("[TB] FAIL post_abort_latency: ack at %0d required %0d", at_cyc, k + 3); end
      checks++; if (data !== e.data) begin errors++; $display("[TB] FAIL post_abort_data: got %h required %h", data, e.data); end
    end
  endtask

  initial begin
    $display("[TB] ram_arbiter bench start");
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_latch_and_drop();
    test_priority();
    test_round_robin();
    test_reset_abort();
    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
